// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame/sample sizes, complex sample type and
// the index bit-reversal used between the SDF pipeline and its reorder buffer.
package fft_pkg;

    localparam int FFT_N_LOG2 = 10;
    localparam int FFT_DW     = 24;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_e;

    // Reverses the low nbits of idx; result sits in the low nbits, upper bits zero.
    function automatic logic [15:0] bitrev(input logic [15:0] idx, input int nbits);
        logic [15:0] src;
        logic [15:0] res;
        src = idx;
        res = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < nbits) begin
                res = {res[14:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_dpram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset on
// the array or the read register.
module fft_dpram
    import fft_pkg::*;
#(
    parameter int AW  = 11,
    parameter int DWR = 48
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DWR-1:0] wr_data,
    input  logic [AW-1:0]  rd_addr,
    output logic [DWR-1:0] rd_data
);

    logic [DWR-1:0] mem_q [2**AW];
    logic [DWR-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes each frame bit-reversed into one bank, streams
// the other bank out in natural order. Optional frame markers via FFT_REORDER_SOF_EN.
//
// state     | meaning
// RD_IDLE   | no completed frame pending, output idle
// RD_ACTIVE | streaming rd_bank out, one read per cycle
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DW     = FFT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] din_r,
    input  logic [DW-1:0] din_i,
    output logic          out_valid,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i
`ifdef FFT_REORDER_SOF_EN
    ,
    output logic          out_sof,
    output logic          out_eof
`endif
);

    localparam int AW = N_LOG2 + 1;
    localparam logic [N_LOG2-1:0] CNT_MAX = '1;

    logic [N_LOG2-1:0] wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              frame_done;
    logic [N_LOG2-1:0] wr_rev;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [2*DW-1:0]   ram_rd;

    rd_state_e         rd_state_q, rd_state_d;
    logic [N_LOG2-1:0] rd_cnt_q, rd_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic              rd_en;

    logic              rd_vld_q, rd_vld_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     dout_r_q, dout_r_d;
    logic [DW-1:0]     dout_i_q, dout_i_d;

    // frame_done is combinational so the read of a finished bank starts on the
    // same edge that stores its last sample.
    always_comb begin
        frame_done = in_valid && (wr_cnt_q == CNT_MAX);
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        if (in_valid) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (frame_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
        wr_rev  = N_LOG2'(bitrev(16'(wr_cnt_q), N_LOG2));
        wr_addr = {wr_bank_q, wr_rev};
        rd_addr = {rd_bank_q, rd_cnt_q};
        rd_en   = (rd_state_q == RD_ACTIVE);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (frame_done) begin
                    rd_state_d = RD_ACTIVE;
                    rd_bank_d  = wr_bank_q;
                    rd_cnt_d   = '0;
                end
            end
            RD_ACTIVE: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == CNT_MAX) begin
                    if (frame_done) begin
                        rd_bank_d = wr_bank_q;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_vld_d    = rd_en;
        out_valid_d = rd_vld_q;
        dout_r_d    = rd_vld_q ? ram_rd[2*DW-1:DW] : dout_r_q;
        dout_i_d    = rd_vld_q ? ram_rd[DW-1:0]    : dout_i_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_state_q  <= RD_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_vld_q    <= rd_vld_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

`ifdef FFT_REORDER_SOF_EN
    logic rd_sof_q, rd_sof_d;
    logic rd_eof_q, rd_eof_d;
    logic out_sof_q, out_sof_d;
    logic out_eof_q, out_eof_d;

    always_comb begin
        rd_sof_d  = rd_en && (rd_cnt_q == '0);
        rd_eof_d  = rd_en && (rd_cnt_q == CNT_MAX);
        out_sof_d = rd_sof_q;
        out_eof_d = rd_eof_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sof_q  <= 1'b0;
            rd_eof_q  <= 1'b0;
            out_sof_q <= 1'b0;
            out_eof_q <= 1'b0;
        end else begin
            rd_sof_q  <= rd_sof_d;
            rd_eof_q  <= rd_eof_d;
            out_sof_q <= out_sof_d;
            out_eof_q <= out_eof_d;
        end
    end

    assign out_sof = out_sof_q;
    assign out_eof = out_eof_q;
`endif

    fft_dpram #(
        .AW  (AW),
        .DWR (2*DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_valid),
        .wr_addr (wr_addr),
        .wr_data ({din_r, din_i}),
        .rd_addr (rd_addr),
        .rd_data (ram_rd)
    );

`ifndef SYNTHESIS
    // A new frame may only complete while the reader is idle or on its last index.
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_done && (rd_state_q == RD_ACTIVE) && (rd_cnt_q != CNT_MAX)))
        else $error("reorder: frame completed while previous bank still being read");
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed checks on an 8-point instance plus a random soak on a 1024-point instance.
module tb_fft_bitrev_reorder;

    localparam int DW = 24;
    localparam int N  = 8;
    localparam int NS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid;
    logic signed [DW-1:0] din_r, din_i;
    logic out_valid;
    logic signed [DW-1:0] dout_r, dout_i;

    logic s_in_valid;
    logic signed [DW-1:0] s_din_r, s_din_i;
    logic s_out_valid;
    logic signed [DW-1:0] s_dout_r, s_dout_i;

`ifdef FFT_REORDER_SOF_EN
    logic out_sof, out_eof, s_out_sof, s_out_eof;
`endif

    fft_bitrev_reorder #(.N_LOG2(3), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din_r(din_r), .din_i(din_i),
        .out_valid(out_valid), .dout_r(dout_r), .dout_i(dout_i)
`ifdef FFT_REORDER_SOF_EN
        , .out_sof(out_sof), .out_eof(out_eof)
`endif
    );

    fft_bitrev_reorder #(.N_LOG2(10), .DW(DW)) dut_soak (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .din_r(s_din_r), .din_i(s_din_i),
        .out_valid(s_out_valid), .dout_r(s_dout_r), .dout_i(s_dout_i)
`ifdef FFT_REORDER_SOF_EN
        , .out_sof(s_out_sof), .out_eof(s_out_eof)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Captured output stream of the 8-point instance.
    logic signed [DW-1:0] cap_r[$], cap_i[$];
    bit cap_sof[$], cap_eof[$];
    int cap_cyc[$];

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            cap_r.push_back(dout_r);
            cap_i.push_back(dout_i);
            cap_cyc.push_back(cyc);
`ifdef FFT_REORDER_SOF_EN
            cap_sof.push_back(out_sof);
            cap_eof.push_back(out_eof);
`else
            cap_sof.push_back(1'b0);
            cap_eof.push_back(1'b0);
`endif
        end
    end

    // Soak scoreboard: expected natural-order samples, consumed as they appear.
    logic signed [DW-1:0] s_exp_r[$], s_exp_i[$];
    always @(negedge clk) begin
        if (rst_n && s_out_valid) begin
            if (s_exp_r.size() == 0) begin
                n_total++;
                $display("FAIL soak_extra_output: got %0h expected no output", s_dout_r);
            end else begin
                chk("soak_r", s_dout_r, s_exp_r.pop_front());
                chk("soak_i", s_dout_i, s_exp_i.pop_front());
            end
        end
    end

    logic signed [DW-1:0] exp_r[$], exp_i[$];
    logic signed [DW-1:0] fr_r[N], fr_i[N];
    int br[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int last_edge;

    typedef struct {
        logic signed [DW-1:0] in_r;
        logic signed [DW-1:0] exp_r;
        bit                   exp_sof;
        bit                   exp_eof;
    } vec_t;
    vec_t tv[N];

    task automatic drive(input logic v, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        @(posedge clk);
        #1;
        in_valid = v;
        din_r    = r;
        din_i    = i;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0);
    endtask

    // Sends fr_r/fr_i (natural order) in bit-reversed order, gap idle cycles after each sample.
    task automatic send_frame(input int gap);
        for (int k = 0; k < N; k++) begin
            exp_r.push_back(fr_r[k]);
            exp_i.push_back(fr_i[k]);
        end
        for (int j = 0; j < N; j++) begin
            drive(1'b1, fr_r[br[j]], fr_i[br[j]]);
            last_edge = cyc + 1;
            if (j < N - 1) idle(gap);
        end
    endtask

    task automatic wait_caps(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (cap_r.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk(name, 64'(cap_r.size() >= n), 64'(1));
    endtask

    task automatic check_caps(input string tag);
        for (int k = 0; k < exp_r.size() && k < cap_r.size(); k++) begin
            chk({tag, "_r"}, cap_r[k], exp_r[k]);
            chk({tag, "_i"}, cap_i[k], exp_i[k]);
`ifdef FFT_REORDER_SOF_EN
            chk({tag, "_sof"}, 64'(cap_sof[k]), 64'((k % N) == 0));
            chk({tag, "_eof"}, 64'(cap_eof[k]), 64'((k % N) == N - 1));
`endif
        end
        cap_r.delete(); cap_i.delete(); cap_sof.delete(); cap_eof.delete(); cap_cyc.delete();
        exp_r.delete(); exp_i.delete();
    endtask

    task automatic s_drive(input logic v, input logic signed [DW-1:0] r, input logic signed [DW-1:0] i);
        @(posedge clk);
        #1;
        s_in_valid = v;
        s_din_r    = r;
        s_din_i    = i;
    endtask

    function automatic int rev10(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 10; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic signed [DW-1:0] sr[NS], si[NS];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; din_r = '0; din_i = '0;
        s_in_valid = 1'b0; s_din_r = '0; s_din_i = '0;

        tv[0] = '{24'sd0,   24'sd0,   1'b1, 1'b0};
        tv[1] = '{24'sd400, 24'sd100, 1'b0, 1'b0};
        tv[2] = '{24'sd200, 24'sd200, 1'b0, 1'b0};
        tv[3] = '{24'sd600, 24'sd300, 1'b0, 1'b0};
        tv[4] = '{24'sd100, 24'sd400, 1'b0, 1'b0};
        tv[5] = '{24'sd500, 24'sd500, 1'b0, 1'b0};
        tv[6] = '{24'sd300, 24'sd600, 1'b0, 1'b0};
        tv[7] = '{24'sd700, 24'sd700, 1'b0, 1'b1};

        // 1: reset state and quiet release
        #23;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_dout_r", dout_r, 24'sd0);
        chk("rst_dout_i", dout_i, 24'sd0);
`ifdef FFT_REORDER_SOF_EN
        chk("rst_sof_eof", {out_sof, out_eof}, 2'b00);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("quiet_after_reset", 64'(cap_r.size()), 64'(0));

        // 2: single frame from the vector table
        for (int j = 0; j < N; j++) begin
            drive(1'b1, tv[j].in_r, -tv[j].in_r);
            last_edge = cyc + 1;
        end
        idle(1);
        wait_caps("single_count", N, 30);
        if (cap_r.size() >= N) begin
            chk("single_latency", 64'(cap_cyc[0]), 64'(last_edge + 2));
            chk("single_contig", 64'(cap_cyc[N-1] - cap_cyc[0]), 64'(N - 1));
            for (int j = 0; j < N; j++) begin
                chk("single_r", cap_r[j], tv[j].exp_r);
                chk("single_i", cap_i[j], -tv[j].exp_r);
`ifdef FFT_REORDER_SOF_EN
                chk("single_sof", 64'(cap_sof[j]), 64'(tv[j].exp_sof));
                chk("single_eof", 64'(cap_eof[j]), 64'(tv[j].exp_eof));
`endif
            end
        end
        idle(4);
        chk("single_no_extra", 64'(cap_r.size()), 64'(N));
        check_caps("single_flush");

        // 3: three back-to-back frames including full-scale values
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                fr_r[k] = DW'(f * 1000 + k * 10 + 1);
                fr_i[k] = DW'(-(f * 1000 + k * 7 + 3));
            end
            if (f == 2) begin
                fr_r[0] = 24'sh800000; fr_i[0] = 24'sh7fffff;
                fr_r[7] = 24'sh7fffff; fr_i[7] = 24'sh800000;
            end
            send_frame(0);
        end
        idle(1);
        wait_caps("b2b_count", 3 * N, 60);
        if (cap_r.size() >= 3 * N)
            chk("b2b_contig", 64'(cap_cyc[3*N-1] - cap_cyc[0]), 64'(3 * N - 1));
        check_caps("b2b");

        // 4: gapped input, one sample every third cycle
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                fr_r[k] = DW'(-(5000 + f * 100 + k));
                fr_i[k] = DW'(7000 + f * 100 + k * 3);
            end
            send_frame(2);
        end
        idle(1);
        wait_caps("gap_count", 2 * N, 80);
        if (cap_r.size() >= 2 * N) begin
            chk("gap_contig0", 64'(cap_cyc[N-1] - cap_cyc[0]), 64'(N - 1));
            chk("gap_contig1", 64'(cap_cyc[2*N-1] - cap_cyc[N]), 64'(N - 1));
        end
        check_caps("gap");

        // 5: reset while output index 4 is on dout, with a partial frame pending
        for (int k = 0; k < N; k++) begin
            fr_r[k] = DW'(50 + k);
            fr_i[k] = DW'(60 + k);
        end
        send_frame(0);
        for (int j = 0; j < 5; j++) drive(1'b1, DW'(9000 + j), DW'(9100 + j));
        idle(1);
        wait_caps("midrd_reach4", 5, 30);
        rst_n = 1'b0;
        #1;
        chk("midrd_valid_drop", 64'(out_valid), 64'(0));
        chk("midrd_dout_clear", dout_r, 24'sd0);
        if (cap_r.size() >= 5) chk("midrd_idx4", cap_r[4], 24'sd54);
        repeat (3) @(negedge clk);
        cap_r.delete(); cap_i.delete(); cap_sof.delete(); cap_eof.delete(); cap_cyc.delete();
        exp_r.delete(); exp_i.delete();
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            fr_r[k] = DW'(70 + k * 11);
            fr_i[k] = DW'(-(80 + k * 13));
        end
        send_frame(0);
        idle(1);
        wait_caps("after_rst_count", N, 30);
        idle(10);
        chk("after_rst_no_extra", 64'(cap_r.size()), 64'(N));
        check_caps("after_rst");

        // 6: soak on the 1024-point instance with random data and gaps
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < NS; k++) begin
                sr[k] = DW'($urandom);
                si[k] = DW'($urandom);
                s_exp_r.push_back(sr[k]);
                s_exp_i.push_back(si[k]);
            end
            for (int j = 0; j < NS; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) s_drive(1'b0, '0, '0);
                end
                s_drive(1'b1, sr[rev10(j)], si[rev10(j)]);
            end
        end
        s_drive(1'b0, '0, '0);
        for (int k = 0; k < 3000 && s_exp_r.size() != 0; k++) @(negedge clk);
        #2;
        chk("soak_drained", 64'(s_exp_r.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
